// File: rtl/mem_writeback_if.sv
// Signal bundle between the ALU result stage, the data-memory bus and the
// commit targets (register file, SP, flags, PC) around mem_writeback.
interface mem_writeback_if;
    logic        en;
    logic [7:0]  alu_control;
    logic [15:0] alu_out;
    logic [15:0] alu_mem_data;
    logic        alu_write;
    logic        alu_should_branch;
    logic [3:0]  alu_flags;
    logic [15:0] alu_sp;
    logic [2:0]  rD_sel;

    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    logic        reg_we;
    logic [2:0]  reg_sel;
    logic [15:0] reg_data;
    logic        sp_we;
    logic [15:0] sp_data;
    logic        flags_we;
    logic [3:0]  flags_out;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        busy;
    logic        done;
    logic        bus_error;

    modport slave (
        input  en, alu_control, alu_out, alu_mem_data, alu_write,
               alu_should_branch, alu_flags, alu_sp, rD_sel,
               mem_rdata, mem_ready,
        output mem_addr, mem_wdata, mem_we, mem_req,
               reg_we, reg_sel, reg_data, sp_we, sp_data, flags_we, flags_out,
               pc_load, pc_value, busy, done, bus_error
    );

    modport master (
        output en, alu_control, alu_out, alu_mem_data, alu_write,
               alu_should_branch, alu_flags, alu_sp, rD_sel,
               mem_rdata, mem_ready,
        input  mem_addr, mem_wdata, mem_we, mem_req,
               reg_we, reg_sel, reg_data, sp_we, sp_data, flags_we, flags_out,
               pc_load, pc_value, busy, done, bus_error
    );
endinterface

// File: rtl/mem_writeback.sv
// Writeback stage: captures one ALU result, runs a req/ready memory transfer for
// LD/ST/PUSH/POP, then commits all targets in one cycle. MEM_TIMEOUT_EN adds a ready-wait timeout.
module mem_writeback #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    mem_writeback_if.slave bus
);

    localparam logic [7:0] OPC_ADD  = 8'h01;
    localparam logic [7:0] OPC_SUB  = 8'h02;
    localparam logic [7:0] OPC_ADC  = 8'h03;
    localparam logic [7:0] OPC_SBB  = 8'h04;
    localparam logic [7:0] OPC_AND  = 8'h05;
    localparam logic [7:0] OPC_OR   = 8'h06;
    localparam logic [7:0] OPC_XOR  = 8'h07;
    localparam logic [7:0] OPC_NOT  = 8'h08;
    localparam logic [7:0] OPC_NEG  = 8'h09;
    localparam logic [7:0] OPC_SHL  = 8'h0A;
    localparam logic [7:0] OPC_SHR  = 8'h0B;
    localparam logic [7:0] OPC_SAR  = 8'h0C;
    localparam logic [7:0] OPC_CMP  = 8'h0D;
    localparam logic [7:0] OPC_TEST = 8'h0E;
    localparam logic [7:0] OPC_JMP  = 8'h20;
    localparam logic [7:0] OPC_LD   = 8'h30;
    localparam logic [7:0] OPC_ST   = 8'h31;
    localparam logic [7:0] OPC_PUSH = 8'h32;
    localparam logic [7:0] OPC_POP  = 8'h33;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_opc;
    logic [15:0] r_alu_out;
    logic [15:0] r_mem_data;
    logic [15:0] r_sp;
    logic [15:0] r_rdata;
    logic        r_write;
    logic        r_branch;
    logic [3:0]  r_flags;
    logic [2:0]  r_rd_sel;

    logic        w_accept;
    logic        w_in_is_mem;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_no_reg;
    logic        w_flag_op;
    logic        w_commit;
    logic        w_timeout;
    logic        w_timed_out;

    assign w_accept    = (r_state == IDLE) && bus.en;
    assign w_in_is_mem = bus.alu_control inside {OPC_LD, OPC_ST, OPC_PUSH, OPC_POP};
    assign w_is_load   = r_opc inside {OPC_LD, OPC_POP};
    assign w_is_store  = r_opc inside {OPC_ST, OPC_PUSH};
    assign w_no_reg    = r_opc inside {OPC_ST, OPC_PUSH, OPC_CMP, OPC_TEST, OPC_JMP};
    assign w_flag_op   = r_opc inside {OPC_ADD, OPC_SUB, OPC_ADC, OPC_SBB, OPC_AND,
                                       OPC_OR, OPC_XOR, OPC_NOT, OPC_NEG, OPC_SHL,
                                       OPC_SHR, OPC_SAR, OPC_CMP, OPC_TEST};
    assign w_commit    = (r_state == COMMIT);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opc      <= '0;
            r_alu_out  <= '0;
            r_mem_data <= '0;
            r_sp       <= '0;
            r_rdata    <= '0;
            r_write    <= 1'b0;
            r_branch   <= 1'b0;
            r_flags    <= '0;
            r_rd_sel   <= '0;
        end else begin
            if (w_accept) begin
                r_opc      <= bus.alu_control;
                r_alu_out  <= bus.alu_out;
                r_mem_data <= bus.alu_mem_data;
                r_sp       <= bus.alu_sp;
                r_write    <= bus.alu_write;
                r_branch   <= bus.alu_should_branch;
                r_flags    <= bus.alu_flags;
                r_rd_sel   <= bus.rD_sel;
            end
            if ((r_state == MEM_WAIT) && bus.mem_ready) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timed_out;
    logic             r_bus_error;

    // Fires on the last permitted non-ready wait cycle so COMMIT follows directly.
    assign w_timeout = (r_state == MEM_WAIT) && !bus.mem_ready
                    && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt  <= '0;
            r_timed_out <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait_cnt  <= '0;
                r_timed_out <= 1'b0;
            end else if ((r_state == MEM_WAIT) && !bus.mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timed_out <= 1'b1;
                r_bus_error <= 1'b1;
            end
        end
    end

    assign w_timed_out   = r_timed_out;
    assign bus.bus_error = r_bus_error;
`else
    assign w_timeout     = 1'b0;
    assign w_timed_out   = 1'b0;
    assign bus.bus_error = 1'b0;
`endif

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next_state  = r_state;
        bus.mem_req   = (r_state == MEM_WAIT);
        bus.mem_addr  = r_alu_out;
        bus.mem_wdata = r_mem_data;
        bus.mem_we    = w_is_store;
        bus.reg_we    = 1'b0;
        bus.reg_sel   = r_rd_sel;
        bus.reg_data  = w_is_load ? r_rdata : r_alu_out;
        bus.sp_we     = 1'b0;
        bus.sp_data   = r_sp;
        bus.flags_we  = 1'b0;
        bus.flags_out = r_flags;
        bus.pc_load   = 1'b0;
        bus.pc_value  = r_alu_out;
        bus.busy      = (r_state != IDLE);
        bus.done      = w_commit;

        unique case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_next_state = w_in_is_mem ? MEM_WAIT : COMMIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready || w_timeout) begin
                    w_next_state = COMMIT;
                end
            end
            COMMIT: begin
                w_next_state = IDLE;
                bus.reg_we   = r_write && !w_no_reg && !w_timed_out;
                bus.sp_we    = (r_opc inside {OPC_PUSH, OPC_POP}) && !w_timed_out;
                bus.flags_we = w_flag_op && !w_timed_out;
                bus.pc_load  = (r_opc == OPC_JMP) && r_branch;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_writeback.sv
// Randomized self-checking bench for mem_writeback against a transaction-level
// model of the commit rules; the timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_writeback;

    localparam logic [7:0] OPC_NOP  = 8'h00;
    localparam logic [7:0] OPC_ADD  = 8'h01;
    localparam logic [7:0] OPC_SUB  = 8'h02;
    localparam logic [7:0] OPC_ADC  = 8'h03;
    localparam logic [7:0] OPC_SBB  = 8'h04;
    localparam logic [7:0] OPC_AND  = 8'h05;
    localparam logic [7:0] OPC_OR   = 8'h06;
    localparam logic [7:0] OPC_XOR  = 8'h07;
    localparam logic [7:0] OPC_NOT  = 8'h08;
    localparam logic [7:0] OPC_NEG  = 8'h09;
    localparam logic [7:0] OPC_SHL  = 8'h0A;
    localparam logic [7:0] OPC_SHR  = 8'h0B;
    localparam logic [7:0] OPC_SAR  = 8'h0C;
    localparam logic [7:0] OPC_CMP  = 8'h0D;
    localparam logic [7:0] OPC_TEST = 8'h0E;
    localparam logic [7:0] OPC_MOV  = 8'h10;
    localparam logic [7:0] OPC_LDI  = 8'h11;
    localparam logic [7:0] OPC_JMP  = 8'h20;
    localparam logic [7:0] OPC_LD   = 8'h30;
    localparam logic [7:0] OPC_ST   = 8'h31;
    localparam logic [7:0] OPC_PUSH = 8'h32;
    localparam logic [7:0] OPC_POP  = 8'h33;

    typedef struct {
        logic [7:0]  opc;
        logic [15:0] out;
        logic [15:0] mdata;
        logic [15:0] sp;
        logic [15:0] rdata;
        logic        wr;
        logic        br;
        logic [3:0]  flags;
        logic [2:0]  rd;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_bus_error = 1'b0;

    logic [7:0] opc_list [22] = '{OPC_NOP, OPC_ADD, OPC_SUB, OPC_ADC, OPC_SBB, OPC_AND,
                                  OPC_OR, OPC_XOR, OPC_NOT, OPC_NEG, OPC_SHL, OPC_SHR,
                                  OPC_SAR, OPC_CMP, OPC_TEST, OPC_MOV, OPC_LDI, OPC_JMP,
                                  OPC_LD, OPC_ST, OPC_PUSH, OPC_POP};

    always #5 clk = ~clk;

    mem_writeback_if ifc ();

    mem_writeback #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [7:0] opc, input logic [15:0] out,
                               input logic [15:0] mdata, input logic [15:0] sp,
                               input logic [15:0] rdata, input logic wr, input logic br,
                               input logic [3:0] flags, input logic [2:0] rd);
        op_t o;
        o.opc = opc; o.out = out; o.mdata = mdata; o.sp = sp; o.rdata = rdata;
        o.wr = wr; o.br = br; o.flags = flags; o.rd = rd;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk(opc_list[$urandom_range(0, 21)], 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), 3'($urandom));
    endfunction

    task automatic junk_inputs();
        ifc.alu_control       = 8'($urandom);
        ifc.alu_out           = 16'($urandom);
        ifc.alu_mem_data      = 16'($urandom);
        ifc.alu_sp            = 16'($urandom);
        ifc.alu_write         = 1'($urandom);
        ifc.alu_should_branch = 1'($urandom);
        ifc.alu_flags         = 4'($urandom);
        ifc.rD_sel            = 3'($urandom);
        ifc.mem_rdata         = 16'($urandom);
    endtask

    task automatic apply(input op_t op);
        ifc.en                = 1'b1;
        ifc.alu_control       = op.opc;
        ifc.alu_out           = op.out;
        ifc.alu_mem_data      = op.mdata;
        ifc.alu_sp            = op.sp;
        ifc.alu_write         = op.wr;
        ifc.alu_should_branch = op.br;
        ifc.alu_flags         = op.flags;
        ifc.rD_sel            = op.rd;
    endtask

    task automatic check_no_pulse(input string tag);
        check({tag, ".pulses"},
              {27'd0, ifc.done, ifc.reg_we, ifc.sp_we, ifc.flags_we, ifc.pc_load}, 32'd0);
    endtask

    // Entered and left one step after a rising edge with the DUT idle.
    task automatic run_op(input op_t op, input int n_wait, input bit poke);
        bit mem, store, load;
        mem   = op.opc inside {OPC_LD, OPC_ST, OPC_PUSH, OPC_POP};
        store = op.opc inside {OPC_ST, OPC_PUSH};
        load  = op.opc inside {OPC_LD, OPC_POP};
        apply(op);
        @(posedge clk); #1;
        ifc.en = 1'b0;
        junk_inputs();
        if (mem) begin
            for (int k = 0; k <= n_wait; k++) begin
                ifc.mem_ready = (k == n_wait);
                if (k == n_wait) ifc.mem_rdata = op.rdata;
                if (poke && k == 0) begin
                    ifc.en = 1'b1;
                    ifc.alu_control = OPC_ADD;
                end
                @(negedge clk);
                check("wait.mem_req", ifc.mem_req, 1);
                check("wait.mem_addr", ifc.mem_addr, op.out);
                check("wait.mem_we", ifc.mem_we, store);
                if (store) check("wait.mem_wdata", ifc.mem_wdata, op.mdata);
                check("wait.busy", ifc.busy, 1);
                check_no_pulse("wait");
                @(posedge clk); #1;
                ifc.mem_ready = 1'b0;
                ifc.en        = 1'b0;
                junk_inputs();
            end
        end
        if (poke) begin
            ifc.en = 1'b1;
            ifc.alu_control = OPC_LD;
        end
        @(negedge clk);
        check("commit.done", ifc.done, 1);
        check("commit.busy", ifc.busy, 1);
        check("commit.mem_req", ifc.mem_req, 0);
        check("commit.reg_we", ifc.reg_we,
              op.wr && !(op.opc inside {OPC_ST, OPC_PUSH, OPC_CMP, OPC_TEST, OPC_JMP}));
        check("commit.reg_sel", ifc.reg_sel, op.rd);
        check("commit.reg_data", ifc.reg_data, load ? op.rdata : op.out);
        check("commit.sp_we", ifc.sp_we, op.opc inside {OPC_PUSH, OPC_POP});
        check("commit.sp_data", ifc.sp_data, op.sp);
        check("commit.flags_we", ifc.flags_we,
              op.opc inside {OPC_ADD, OPC_SUB, OPC_ADC, OPC_SBB, OPC_AND, OPC_OR, OPC_XOR,
                             OPC_NOT, OPC_NEG, OPC_SHL, OPC_SHR, OPC_SAR, OPC_CMP, OPC_TEST});
        check("commit.flags_out", ifc.flags_out, op.flags);
        check("commit.pc_load", ifc.pc_load, (op.opc == OPC_JMP) && op.br);
        check("commit.pc_value", ifc.pc_value, op.out);
        check("commit.bus_error", ifc.bus_error, exp_bus_error);
        @(posedge clk); #1;
        ifc.en = 1'b0;
        if (poke) begin
            @(negedge clk);
            check("post.busy", ifc.busy, 0);
            check("post.mem_req", ifc.mem_req, 0);
            check_no_pulse("post");
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ifc.en = 1'b0;
        ifc.mem_ready = 1'b0;
        junk_inputs();
        #3;
        check("rst.mem_req", ifc.mem_req, 0);
        check("rst.mem_addr", ifc.mem_addr, 0);
        check("rst.mem_we", ifc.mem_we, 0);
        check("rst.mem_wdata", ifc.mem_wdata, 0);
        check("rst.reg", {ifc.reg_sel, ifc.reg_data}, 0);
        check("rst.sp_flags_pc", {ifc.sp_data, ifc.flags_out, ifc.pc_value}, 0);
        check("rst.busy", ifc.busy, 0);
        check("rst.bus_error", ifc.bus_error, 0);
        check_no_pulse("rst");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(mk(OPC_ADD, 16'h1234, 16'h5555, 16'h7777, 16'h0, 1'b1, 1'b0, 4'b0010, 3'd3), 0, 1'b0);
        run_op(mk(OPC_LD, 16'h0100, 16'h1111, 16'h2222, 16'hBEEF, 1'b1, 1'b0, 4'b1111, 3'd5), 3, 1'b0);
        run_op(mk(OPC_PUSH, 16'hFFFE, 16'h00AA, 16'hFFFE, 16'h3333, 1'b1, 1'b0, 4'b0101, 3'd1), 0, 1'b0);
        run_op(mk(OPC_JMP, 16'h0040, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 4'b0001, 3'd2), 0, 1'b0);
        run_op(mk(OPC_JMP, 16'h0080, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 4'b0001, 3'd2), 0, 1'b0);

`ifdef MEM_TIMEOUT_EN
        apply(mk(OPC_LD, 16'h0200, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 4'b0, 3'd4));
        @(posedge clk); #1;
        ifc.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("tmo.mem_req", ifc.mem_req, 1);
            check("tmo.bus_error_pre", ifc.bus_error, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("tmo.mem_req_drop", ifc.mem_req, 0);
        check("tmo.bus_error", ifc.bus_error, 1);
        check("tmo.done", ifc.done, 1);
        check("tmo.writes", {ifc.reg_we, ifc.sp_we, ifc.flags_we}, 0);
        exp_bus_error = 1'b1;
        @(posedge clk); #1;
        run_op(mk(OPC_SUB, 16'h4321, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 4'b1000, 3'd6), 0, 1'b0);
`else
        run_op(mk(OPC_POP, 16'h0300, 16'h0, 16'h8000, 16'hCAFE, 1'b1, 1'b0, 4'b0, 3'd7), 10, 1'b0);
`endif

        apply(mk(OPC_ST, 16'h0400, 16'h5A5A, 16'h0, 16'h0, 1'b0, 1'b0, 4'b0, 3'd0));
        @(posedge clk); #1;
        ifc.en = 1'b0;
        @(negedge clk);
        check("rstw.mem_req_before", ifc.mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstw.mem_req", ifc.mem_req, 0);
        check("rstw.busy", ifc.busy, 0);
        check("rstw.mem_addr", ifc.mem_addr, 0);
        check("rstw.bus_error", ifc.bus_error, 0);
        check_no_pulse("rstw");
        exp_bus_error = 1'b0;
        @(posedge clk); #1;
        check_no_pulse("rstw.edge");
        rst = 1'b0;
        run_op(mk(OPC_CMP, 16'h9999, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 4'b0100, 3'd2), 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            run_op(rand_op(), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
